wb_rr_arbiter: RTL and testbench

WB_RR_ARBITER -- requirements
Module: wb_rr_arbiter

---
 rtl/wb_arb_pkg.sv | 23 ++
 rtl/wb_rr_arbiter_if.sv | 49 ++++
 rtl/wb_rr_arbiter_pick.sv | 31 +++
 rtl/wb_rr_arbiter.sv | 149 ++++++++++++++
 tb/tb_wb_rr_arbiter.sv | 284 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/wb_arb_pkg.sv
// Shared definitions for the round-robin Wishbone arbiter.
//   arb_state_e : arbiter FSM encoding (IDLE / BUSY / ABORT)
//   clog2_min1  : ceil(log2(value)), never less than 1, used to size
//                 grant-index and watchdog registers so a degenerate
//                 parameter never produces a zero-width vector.
package wb_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUSY  = 2'd1,
    ST_ABORT = 2'd2
  } arb_state_e;

  function automatic int clog2_min1(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/wb_rr_arbiter_if.sv
// Bundle of every bus signal around the arbiter, named after the arbiter
// ports so a wrapper or bench can connect one-to-one.
//   modport master : the requesting-master side (drives m_* requests,
//                    receives read data / ack / err)
//   modport slave  : the shared slave side (receives s_* request,
//                    drives read data / ack / err)
//   modport arb    : the arbiter's own view of both sides
interface wb_rr_arbiter_if #(
  parameter int NUM_MASTERS = 2,
  parameter int AW          = 32,
  parameter int DW          = 32
);
  logic [NUM_MASTERS-1:0]        m_cyc_i;
  logic [NUM_MASTERS-1:0]        m_stb_i;
  logic [NUM_MASTERS-1:0]        m_we_i;
  logic [NUM_MASTERS*DW/8-1:0]   m_sel_i;
  logic [NUM_MASTERS*AW-1:0]     m_adr_i;
  logic [NUM_MASTERS*DW-1:0]     m_dat_i;
  logic [DW-1:0]                 m_dat_o;
  logic [NUM_MASTERS-1:0]        m_ack_o;
  logic [NUM_MASTERS-1:0]        m_err_o;

  logic                          s_cyc_o;
  logic                          s_stb_o;
  logic                          s_we_o;
  logic [DW/8-1:0]               s_sel_o;
  logic [AW-1:0]                 s_adr_o;
  logic [DW-1:0]                 s_dat_o;
  logic [DW-1:0]                 s_dat_i;
  logic                          s_ack_i;
  logic                          s_err_i;

  modport master (
    output m_cyc_i, m_stb_i, m_we_i, m_sel_i, m_adr_i, m_dat_i,
    input  m_dat_o, m_ack_o, m_err_o
  );

  modport slave (
    input  s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_adr_o, s_dat_o,
    output s_dat_i, s_ack_i, s_err_i
  );

  modport arb (
    input  m_cyc_i, m_stb_i, m_we_i, m_sel_i, m_adr_i, m_dat_i,
    output m_dat_o, m_ack_o, m_err_o,
    output s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_adr_o, s_dat_o,
    input  s_dat_i, s_ack_i, s_err_i
  );
endinterface

// File: rtl/wb_rr_arbiter_pick.sv
// Circular-priority picker: returns the first asserted request strictly
// after last_i, wrapping around; last_i itself has the lowest priority.
//   req_i   : per-master request vector
//   last_i  : index of the most recently served master
//   pick_o  : chosen index (0 when nothing requests)
//   valid_o : at least one request present
module wb_rr_arbiter_pick #(
  parameter int NUM_MASTERS = 2,
  parameter int IW          = 1
) (
  input  logic [NUM_MASTERS-1:0] req_i,
  input  logic [IW-1:0]          last_i,
  output logic [IW-1:0]          pick_o,
  output logic                   valid_o
);

  int idx;

  // Scan from the farthest candidate to the nearest so the nearest
  // requester after last_i is the final (winning) assignment.
  always_comb begin
    pick_o  = '0;
    valid_o = |req_i;
    idx     = 0;
    for (int k = NUM_MASTERS; k >= 1; k--) begin
      idx = (int'(last_i) + k) % NUM_MASTERS;
      if (req_i[idx]) pick_o = IW'(idx);
    end
  end

endmodule

// File: rtl/wb_rr_arbiter.sv
// Round-robin arbiter sharing one Wishbone slave among NUM_MASTERS masters,
// with a stall watchdog that errors out a transfer the slave never answers.
//   wb_clk_i / wb_rst_n_i      : clock, async active-low reset
//   m_cyc/stb/we/sel/adr/dat_i : packed per-master request buses (master i at slice i)
//   m_dat_o                    : slave read data broadcast to every master
//   m_ack_o / m_err_o          : per-master termination, only the granted bit moves
//   s_cyc/stb/we/sel/adr/dat_o : request of the granted master toward the slave
//   s_dat_i / s_ack_i / s_err_i: slave response
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | no owner; pick next requester after last_grant, own it next edge
// ST_BUSY  | grant_q owns the slave; request passed through combinationally
// ST_ABORT | watchdog fired; slave side parked until owner drops cyc
module wb_rr_arbiter
  import wb_arb_pkg::*;
#(
  parameter int NUM_MASTERS    = 2,
  parameter int AW             = 32,
  parameter int DW             = 32,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic                        wb_clk_i,
  input  logic                        wb_rst_n_i,
  input  logic [NUM_MASTERS-1:0]      m_cyc_i,
  input  logic [NUM_MASTERS-1:0]      m_stb_i,
  input  logic [NUM_MASTERS-1:0]      m_we_i,
  input  logic [NUM_MASTERS*DW/8-1:0] m_sel_i,
  input  logic [NUM_MASTERS*AW-1:0]   m_adr_i,
  input  logic [NUM_MASTERS*DW-1:0]   m_dat_i,
  output logic [DW-1:0]               m_dat_o,
  output logic [NUM_MASTERS-1:0]      m_ack_o,
  output logic [NUM_MASTERS-1:0]      m_err_o,
  output logic                        s_cyc_o,
  output logic                        s_stb_o,
  output logic                        s_we_o,
  output logic [DW/8-1:0]             s_sel_o,
  output logic [AW-1:0]               s_adr_o,
  output logic [DW-1:0]               s_dat_o,
  input  logic [DW-1:0]               s_dat_i,
  input  logic                        s_ack_i,
  input  logic                        s_err_i
);

  localparam int SW = DW / 8;
  localparam int IW = clog2_min1(NUM_MASTERS);
  localparam int CW = clog2_min1(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] WD_MAX  = '1;
  localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  arb_state_e    state_q, state_d;
  logic [IW-1:0] grant_q, grant_d;
  logic [IW-1:0] last_q, last_d;
  logic [CW-1:0] wdog_q, wdog_d;

  logic [IW-1:0] pick_idx;
  logic          pick_valid;
  logic          busy, g_cyc, g_stb, stall, timeout;

  wb_rr_arbiter_pick #(
    .NUM_MASTERS (NUM_MASTERS),
    .IW          (IW)
  ) u_pick (
    .req_i   (m_cyc_i),
    .last_i  (last_q),
    .pick_o  (pick_idx),
    .valid_o (pick_valid)
  );

  assign busy  = (state_q == ST_BUSY);
  assign g_cyc = m_cyc_i[grant_q];
  assign g_stb = m_stb_i[grant_q];
  assign stall = busy & g_stb & ~s_ack_i & ~s_err_i;

  // wdog_q counts stalls already completed, so when it holds TIMEOUT-1 the
  // current stalled cycle is number TIMEOUT and the error fires right now.
  // An ack or err in the same cycle means this is not a stall at all.
  assign timeout = (TIMEOUT_CYCLES != 0) && stall && (wdog_q == TO_LAST);

  assign m_dat_o = s_dat_i;

  always_comb begin
    s_cyc_o = 1'b0;
    s_stb_o = 1'b0;
    s_we_o  = 1'b0;
    s_sel_o = '0;
    s_adr_o = '0;
    s_dat_o = '0;
    m_ack_o = '0;
    m_err_o = '0;
    if (busy) begin
      s_cyc_o = g_cyc;
      s_stb_o = g_stb;
      s_we_o  = m_we_i[grant_q];
      s_sel_o = m_sel_i[int'(grant_q)*SW +: SW];
      s_adr_o = m_adr_i[int'(grant_q)*AW +: AW];
      s_dat_o = m_dat_i[int'(grant_q)*DW +: DW];
      m_ack_o[grant_q] = s_ack_i;
      m_err_o[grant_q] = s_err_i | timeout;
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    wdog_d  = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          grant_d = pick_idx;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (!g_cyc) begin
          state_d = ST_IDLE;
          last_d  = grant_q;
        end else if (timeout) begin
          state_d = ST_ABORT;
        end else if (stall) begin
          wdog_d = (wdog_q == WD_MAX) ? wdog_q : wdog_q + 1'b1;
        end
      end
      ST_ABORT: begin
        if (!g_cyc) begin
          state_d = ST_IDLE;
          last_d  = grant_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      last_q  <= IW'(NUM_MASTERS - 1);
      wdog_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      wdog_q  <= wdog_d;
    end
  end

endmodule

// File: tb/tb_wb_rr_arbiter.sv
module tb_wb_rr_arbiter;

  localparam int NM = 2;
  localparam int AW = 16;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int TO = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  wb_rr_arbiter_if #(.NUM_MASTERS(NM), .AW(AW), .DW(DW)) bus ();

  logic [NM-1:0] cyc, stb, we;
  logic [SW-1:0] sel  [NM];
  logic [AW-1:0] adr  [NM];
  logic [DW-1:0] wdat [NM];
  logic          s_ack, s_err;
  logic [DW-1:0] s_rdat;

  assign bus.m_cyc_i = cyc;
  assign bus.m_stb_i = stb;
  assign bus.m_we_i  = we;
  assign bus.s_dat_i = s_rdat;
  assign bus.s_ack_i = s_ack;
  assign bus.s_err_i = s_err;
  for (genvar i = 0; i < NM; i++) begin : g_pack
    assign bus.m_sel_i[i*SW +: SW] = sel[i];
    assign bus.m_adr_i[i*AW +: AW] = adr[i];
    assign bus.m_dat_i[i*DW +: DW] = wdat[i];
  end

  wb_rr_arbiter #(
    .NUM_MASTERS    (NM),
    .AW             (AW),
    .DW             (DW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .wb_clk_i   (clk),
    .wb_rst_n_i (rst_n),
    .m_cyc_i    (bus.m_cyc_i),
    .m_stb_i    (bus.m_stb_i),
    .m_we_i     (bus.m_we_i),
    .m_sel_i    (bus.m_sel_i),
    .m_adr_i    (bus.m_adr_i),
    .m_dat_i    (bus.m_dat_i),
    .m_dat_o    (bus.m_dat_o),
    .m_ack_o    (bus.m_ack_o),
    .m_err_o    (bus.m_err_o),
    .s_cyc_o    (bus.s_cyc_o),
    .s_stb_o    (bus.s_stb_o),
    .s_we_o     (bus.s_we_o),
    .s_sel_o    (bus.s_sel_o),
    .s_adr_o    (bus.s_adr_o),
    .s_dat_o    (bus.s_dat_o),
    .s_dat_i    (bus.s_dat_i),
    .s_ack_i    (bus.s_ack_i),
    .s_err_i    (bus.s_err_i)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Behavioural model: who owns the slave, whether the owner was aborted,
  // who was served last, and how many consecutive stalls have been seen.
  int owner    = -1;
  bit aborting = 1'b0;
  int last_srv = NM - 1;
  int stalls   = 0;

  function automatic int first_after(input int last, input logic [NM-1:0] req);
    for (int k = 1; k <= NM; k++) begin
      if (req[(last + k) % NM]) return (last + k) % NM;
    end
    return -1;
  endfunction

  function automatic bit serving();
    return (owner >= 0) && !aborting;
  endfunction

  function automatic bit stalled_now();
    return serving() && stb[owner] && !s_ack && !s_err;
  endfunction

  function automatic bit timeout_now();
    return (TO != 0) && stalled_now() && (stalls + 1 == TO);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner    <= -1;
      aborting <= 1'b0;
      last_srv <= NM - 1;
      stalls   <= 0;
    end else if (owner < 0) begin
      if (cyc != '0) owner <= first_after(last_srv, cyc);
      stalls <= 0;
    end else if (!cyc[owner]) begin
      last_srv <= owner;
      owner    <= -1;
      aborting <= 1'b0;
      stalls   <= 0;
    end else if (aborting) begin
      stalls <= 0;
    end else if (timeout_now()) begin
      aborting <= 1'b1;
      stalls   <= 0;
    end else if (stalled_now()) begin
      stalls <= stalls + 1;
    end else begin
      stalls <= 0;
    end
  end

  always @(negedge clk) begin
    logic [NM-1:0] e_ack, e_err;
    e_ack = '0;
    e_err = '0;
    if (serving()) begin
      e_ack[owner] = s_ack;
      e_err[owner] = s_err | timeout_now();
    end
    cmp("s_cyc_o", 64'(bus.s_cyc_o), serving() ? 64'(cyc[owner]) : 64'd0);
    cmp("s_stb_o", 64'(bus.s_stb_o), serving() ? 64'(stb[owner]) : 64'd0);
    cmp("s_we_o",  64'(bus.s_we_o),  serving() ? 64'(we[owner])  : 64'd0);
    cmp("s_sel_o", 64'(bus.s_sel_o), serving() ? 64'(sel[owner]) : 64'd0);
    cmp("s_adr_o", 64'(bus.s_adr_o), serving() ? 64'(adr[owner]) : 64'd0);
    cmp("s_dat_o", 64'(bus.s_dat_o), serving() ? 64'(wdat[owner]) : 64'd0);
    cmp("m_ack_o", 64'(bus.m_ack_o), 64'(e_ack));
    cmp("m_err_o", 64'(bus.m_err_o), 64'(e_err));
    cmp("m_dat_o", 64'(bus.m_dat_o), 64'(s_rdat));
  end

  int acks0, acks1;

  initial begin
    cyc = '0; stb = '0; we = '0;
    s_ack = 1'b0; s_err = 1'b0; s_rdat = '0;
    for (int i = 0; i < NM; i++) begin
      sel[i] = '0; adr[i] = '0; wdat[i] = '0;
    end

    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    #1;
    cmp("reset_s_cyc", 64'(bus.s_cyc_o), 64'd0);
    cmp("reset_ack",   64'(bus.m_ack_o), 64'd0);
    cmp("reset_err",   64'(bus.m_err_o), 64'd0);

    // Both masters request together: master 0 first, one-cycle latency.
    adr[0] = 16'h0100; adr[1] = 16'h0200;
    wdat[0] = 32'hAAAA_0000; wdat[1] = 32'hBBBB_1111;
    sel[0] = 4'hF; sel[1] = 4'h3;
    tick();
    cyc = 2'b11; stb = 2'b11;
    #1 cmp("arb_latency_cyc", 64'(bus.s_cyc_o), 64'd0);
    tick();
    cmp("grant0_cyc", 64'(bus.s_cyc_o), 64'd1);
    cmp("grant0_adr", 64'(bus.s_adr_o), 64'h0100);
    s_ack = 1'b1;
    #1 cmp("grant0_ack", 64'(bus.m_ack_o), 64'b01);
    tick();
    s_ack = 1'b0; cyc[0] = 1'b0; stb[0] = 1'b0;
    #1 cmp("release0_cyc", 64'(bus.s_cyc_o), 64'd0);
    tick();
    cmp("idle_gap_cyc", 64'(bus.s_cyc_o), 64'd0);
    tick();
    cmp("grant1_cyc", 64'(bus.s_cyc_o), 64'd1);
    cmp("grant1_adr", 64'(bus.s_adr_o), 64'h0200);

    // 8-beat burst from master 1 while master 0 waits.
    cyc[0] = 1'b1; stb[0] = 1'b1;
    acks0 = 0; acks1 = 0;
    for (int b = 0; b < 8; b++) begin
      s_ack = 1'b1;
      #1;
      if (bus.m_ack_o[0]) acks0++;
      if (bus.m_ack_o[1]) acks1++;
      cmp("burst_ack_vec", 64'(bus.m_ack_o), 64'b10);
      tick();
    end
    s_ack = 1'b0; cyc[1] = 1'b0; stb[1] = 1'b0;
    cmp("burst_acks_m1", 64'(acks1), 64'd8);
    cmp("burst_acks_m0", 64'(acks0), 64'd0);
    #1 cmp("burst_end_cyc", 64'(bus.s_cyc_o), 64'd0);
    tick();
    cmp("idle_gap2_cyc", 64'(bus.s_cyc_o), 64'd0);
    tick();
    cmp("grant0_after_burst_cyc", 64'(bus.s_cyc_o), 64'd1);
    cmp("grant0_after_burst_adr", 64'(bus.s_adr_o), 64'h0100);

    // Slave never answers: error on the 4th stalled cycle, then ABORT.
    for (int k = 1; k <= 4; k++) begin
      #1 cmp("wdog_err", 64'(bus.m_err_o), (k == 4) ? 64'b01 : 64'b00);
      tick();
    end
    #1;
    cmp("abort_cyc", 64'(bus.s_cyc_o), 64'd0);
    cmp("abort_stb", 64'(bus.s_stb_o), 64'd0);
    cmp("abort_err", 64'(bus.m_err_o), 64'd0);
    tick();
    #1 cmp("abort_hold_cyc", 64'(bus.s_cyc_o), 64'd0);
    cyc = '0; stb = '0;
    tick();

    // Ack lands on the cycle the watchdog would fire.
    cyc[0] = 1'b1; stb[0] = 1'b1;
    tick();
    tick();
    tick();
    tick();
    s_ack = 1'b1;
    #1;
    cmp("ack_vs_timeout_ack", 64'(bus.m_ack_o), 64'b01);
    cmp("ack_vs_timeout_err", 64'(bus.m_err_o), 64'b00);
    tick();
    s_ack = 1'b0;
    #1;
    cmp("busy_kept_cyc", 64'(bus.s_cyc_o), 64'd1);
    cmp("busy_kept_err", 64'(bus.m_err_o), 64'd0);

    // Reset asserted in the middle of a master-1 burst.
    cyc = 2'b10; stb = 2'b10;
    tick();
    tick();
    s_ack = 1'b1;
    #1 cmp("pre_rst_ack", 64'(bus.m_ack_o), 64'b10);
    tick();
    tick();
    #2 rst_n = 1'b0;
    #1;
    cmp("async_rst_cyc", 64'(bus.s_cyc_o), 64'd0);
    cmp("async_rst_ack", 64'(bus.m_ack_o), 64'd0);
    cyc = 2'b11; stb = 2'b11; s_ack = 1'b0;
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    cmp("post_rst_cyc", 64'(bus.s_cyc_o), 64'd1);
    cmp("post_rst_adr", 64'(bus.s_adr_o), 64'h0100);
    s_ack = 1'b1;
    tick();
    cyc = '0; stb = '0; s_ack = 1'b0;

    // Randomized traffic, checked every cycle by the model compare.
    for (int c = 0; c < 3000; c++) begin
      tick();
      for (int i = 0; i < NM; i++) begin
        if ($urandom_range(5) == 0) cyc[i] = ~cyc[i];
        stb[i]  = ($urandom_range(3) != 0);
        we[i]   = $urandom_range(1) != 0;
        sel[i]  = SW'($urandom);
        adr[i]  = AW'($urandom);
        wdat[i] = $urandom;
      end
      s_ack  = ($urandom_range(2) == 0);
      s_err  = ($urandom_range(15) == 0);
      s_rdat = $urandom;
      if (c == 1500) begin
        #1 rst_n = 1'b0;
        #1 rst_n = 1'b1;
      end
    end

    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
